// File: rtl/grab_report_unpacker.sv
// Receive-side decoder for the quad stream grabber's byte-serial harvest report.
// Optional build macro REPORT_UNPACK_LSB_FIRST_EN: bytes within a sample arrive least significant first.
module grab_report_unpacker #(
    parameter int DAT_WIDTH = 72,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    input  logic [7:0]           din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 reporting,
    output logic [DAT_WIDTH-1:0] word_out,
    output logic [1:0]           word_stream,
    output logic [ADDR_BITS-1:0] word_addr,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam int BYTES = DAT_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t                 state, state_nxt;
    logic                   ready_en;
    logic                   accept;
    logic                   last_byte;
    logic                   frame_end;
    logic                   end_ok;
    logic [BCW-1:0]         byte_cnt;
    logic [ADDR_BITS-1:0]   addr_cnt;
    logic [1:0]             strm_cnt;
    logic                   full;
    logic                   ovf;
    logic [DAT_WIDTH-1:0]   asm_q;
    logic [DAT_WIDTH-1:0]   asm_nxt;

    // ready_en keeps din_ready low during reset and releases it one edge later.
    assign din_ready = ready_en & (~word_valid | word_ready);
    assign accept    = din_valid & din_ready & reporting;
    assign last_byte = (byte_cnt == BCW'(BYTES - 1));
    assign end_ok    = full & ~ovf & (byte_cnt == '0);

`ifdef REPORT_UNPACK_LSB_FIRST_EN
    assign asm_nxt = (asm_q >> 8) | (DAT_WIDTH'(din) << (DAT_WIDTH - 8));
`else
    assign asm_nxt = (asm_q << 8) | DAT_WIDTH'(din);
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            IDLE: if (reporting) state_nxt = RECV;
            RECV: begin
                if (!reporting) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            ready_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            byte_cnt    <= '0;
            addr_cnt    <= '0;
            strm_cnt    <= '0;
            full        <= 1'b0;
            ovf         <= 1'b0;
            asm_q       <= '0;
            word_out    <= '0;
            word_stream <= '0;
            word_addr   <= '0;
            word_valid  <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            frame_done <= frame_end & end_ok;
            frame_err  <= frame_end & ~end_ok;

            // Counters sit at zero in IDLE, so a byte on the first reporting cycle starts a word.
            if (frame_end) begin
                byte_cnt <= '0;
                addr_cnt <= '0;
                strm_cnt <= '0;
                full     <= 1'b0;
                ovf      <= 1'b0;
                asm_q    <= '0;
            end else if (accept) begin
                if (full) begin
                    ovf <= 1'b1;
                end else if (last_byte) begin
                    byte_cnt <= '0;
                    asm_q    <= '0;
                    addr_cnt <= addr_cnt + 1'b1;
                    if (addr_cnt == '1) begin
                        strm_cnt <= strm_cnt + 2'd1;
                        if (strm_cnt == 2'd3) full <= 1'b1;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    asm_q    <= asm_nxt;
                end
            end

            // Output register runs independently of the frame state machine.
            if (accept && !full && last_byte) begin
                word_out    <= asm_nxt;
                word_stream <= strm_cnt;
                word_addr   <= addr_cnt;
                word_valid  <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grab_report_unpacker.sv
// Scoreboard bench for grab_report_unpacker: expected words queued at stimulus time, popped on handshake.
module tb_grab_report_unpacker;

    localparam int DW     = 72;
    localparam int AB     = 4;
    localparam int BYTES  = DW / 8;
    localparam int NWORDS = 4 * (1 << AB);
    localparam int FULL   = NWORDS * BYTES;

    typedef struct packed {
        logic [1:0]    s;
        logic [AB-1:0] a;
        logic [DW-1:0] w;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic [7:0]    din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          reporting = 1'b0;
    logic [DW-1:0] word_out;
    logic [1:0]    word_stream;
    logic [AB-1:0] word_addr;
    logic          word_valid;
    logic          word_ready = 1'b1;
    logic          frame_done;
    logic          frame_err;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            word_cnt = 0;
    int            ready_viol = 0;
    int            rdy_mode = 0;
    bit            rnd_valid = 1'b0;
    bit            chk_ready = 1'b0;
    logic [DW-1:0] first_word;
    logic [1:0]    last_s;
    logic [AB-1:0] last_a;

    grab_report_unpacker #(.DAT_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .reporting   (reporting),
        .word_out    (word_out),
        .word_stream (word_stream),
        .word_addr   (word_addr),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic ready_drv();
        int cyc = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            word_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (frame_done && frame_err) begin
                total++; bad++;
                $display("FAIL pulse_both: frame_done=1 frame_err=1, required at most one");
            end
            if (chk_ready && (din_ready !== (!word_valid || word_ready))) ready_viol++;
            if (word_valid && word_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word_unexpected: got s=%0d a=%0d w=%h, none expected",
                             word_stream, word_addr, word_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({word_stream, word_addr, word_out} !== e) begin
                        bad++;
                        $display("FAIL word: got s=%0d a=%0d w=%h, required s=%0d a=%0d w=%h",
                                 word_stream, word_addr, word_out, e.s, e.a, e.w);
                    end
                end
                if (word_cnt == 0) first_word = word_out;
                last_s = word_stream;
                last_a = word_addr;
                word_cnt++;
            end
        end
    endtask

    // Expected words for a frame of n bytes where byte k carries (start+k)[7:0].
    task automatic push_expected(input int n, input int start);
        int   nw;
        exp_t e;
        logic [7:0] b;
        nw = n / BYTES;
        if (nw > NWORDS) nw = NWORDS;
        for (int i = 0; i < nw; i++) begin
            e.s = 2'(i / (1 << AB));
            e.a = AB'(i % (1 << AB));
            e.w = '0;
            for (int j = 0; j < BYTES; j++) begin
                b = 8'(start + i * BYTES + j);
`ifdef REPORT_UNPACK_LSB_FIRST_EN
                e.w = {b, e.w[DW-1:8]};
`else
                e.w = {e.w[DW-9:0], b};
`endif
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bytes(input int n, input int start);
        int k = 0;
        int guard = 0;
        bit acc;
        reporting = 1'b1;
        while (k < n) begin
            din       = 8'(start + k);
            din_valid = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk_sys);
            acc = din_valid && din_ready;
            @(posedge clk_sys);
            #1;
            if (acc) k++;
            guard++;
            if (guard > 20000) begin
                total++; bad++;
                $display("FAIL send_timeout: accepted %0d bytes, required %0d", k, n);
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic end_frame();
        reporting = 1'b0;
        din_valid = 1'b0;
        repeat (12) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_frame(input string tag, input int words, input int d0, input int e0,
                               input int want_done, input int want_err);
        total++;
        if (word_cnt !== words) begin
            bad++; $display("FAIL %s_words: got %0d, required %0d", tag, word_cnt, words);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL %s_pending: %0d words never emitted, required 0", tag, exp_q.size());
        end
        total++;
        if (done_cnt - d0 !== want_done) begin
            bad++; $display("FAIL %s_done: got %0d pulses, required %0d", tag, done_cnt - d0, want_done);
        end
        total++;
        if (err_cnt - e0 !== want_err) begin
            bad++; $display("FAIL %s_err: got %0d pulses, required %0d", tag, err_cnt - e0, want_err);
        end
    endtask

    task automatic run_frame(input string tag, input int n, input int want_done, input int want_err);
        int d0, e0, words;
        d0 = done_cnt; e0 = err_cnt; word_cnt = 0;
        words = (n / BYTES > NWORDS) ? NWORDS : n / BYTES;
        push_expected(n, 0);
        send_bytes(n, 0);
        end_frame();
        check_frame(tag, words, d0, e0, want_done, want_err);
    endtask

    task automatic test_reset();
        rst_sys_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        total++;
        if ({word_out, word_stream, word_addr, word_valid, frame_done, frame_err, din_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: w=%h s=%0d a=%0d v=%b d=%b e=%b rdy=%b, required all 0",
                     word_out, word_stream, word_addr, word_valid, frame_done, frame_err, din_ready);
        end
        @(posedge clk_sys); #1;
        rst_sys_n = 1'b1;
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        total++;
        if (din_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b, required 1", din_ready);
        end
        @(posedge clk_sys); #1;
        chk_ready = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [DW-1:0] want_first;
`ifdef REPORT_UNPACK_LSB_FIRST_EN
        want_first = 72'h080706050403020100;
`else
        want_first = 72'h000102030405060708;
`endif
        rdy_mode = 0; rnd_valid = 1'b0; ready_viol = 0;
        run_frame("full", FULL, 1, 0);
        total++;
        if (first_word !== want_first) begin
            bad++; $display("FAIL full_first_word: got %h, required %h", first_word, want_first);
        end
        total++;
        if ({last_s, last_a} !== {2'd3, AB'((1 << AB) - 1)}) begin
            bad++; $display("FAIL full_last_tag: got s=%0d a=%0d, required s=3 a=%0d", last_s, last_a, (1 << AB) - 1);
        end
        total++;
        if (ready_viol !== 0) begin
            bad++; $display("FAIL full_ready_rule: got %0d violations, required 0", ready_viol);
        end
    endtask

    task automatic test_backpressure();
        rdy_mode = 1; rnd_valid = 1'b1; ready_viol = 0;
        run_frame("bp", FULL, 1, 0);
        total++;
        if (ready_viol !== 0) begin
            bad++; $display("FAIL bp_ready_rule: got %0d violations, required 0", ready_viol);
        end
        rdy_mode = 0; rnd_valid = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic test_short_frame();
        run_frame("short", 300, 0, 1);
        run_frame("after_short", FULL, 1, 0);
    endtask

    task automatic test_long_frame();
        run_frame("long", FULL + 4, 0, 1);
    endtask

    task automatic test_idle_drop();
        int d0, e0, rdy_hi;
        d0 = done_cnt; e0 = err_cnt; word_cnt = 0; rdy_hi = 0;
        reporting = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 8'(8'hA0 + i); din_valid = 1'b1;
            @(negedge clk_sys);
            if (din_ready === 1'b1) rdy_hi++;
            @(posedge clk_sys); #1;
        end
        din_valid = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        total++;
        if (rdy_hi !== 10) begin
            bad++; $display("FAIL idle_ready: high %0d of 10 cycles, required 10", rdy_hi);
        end
        check_frame("idle", 0, d0, e0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; word_cnt = 0;
        push_expected(100, 0);
        send_bytes(100, 0);
        chk_ready = 1'b0;
        rst_sys_n = 1'b0;
        reporting = 1'b0;
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        total++;
        if ({word_out, word_stream, word_addr, word_valid, frame_done, frame_err, din_ready} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: w=%h s=%0d a=%0d v=%b d=%b e=%b rdy=%b, required all 0",
                     word_out, word_stream, word_addr, word_valid, frame_done, frame_err, din_ready);
        end
        @(posedge clk_sys); #1;
        rst_sys_n = 1'b1;
        repeat (6) @(posedge clk_sys);
        #1;
        chk_ready = 1'b1;
        check_frame("midreset", 11, d0, e0, 0, 0);
        run_frame("after_reset", FULL, 1, 0);
    endtask

    initial begin
        fork
            monitor();
            ready_drv();
        join_none
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_idle_drop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grab_report_unpacker.md
# grab_report_unpacker

Receive-side decoder for the byte-serial harvest report emitted by the quad stream grabber. Consumes the 8-bit report stream (valid/ready plus `reporting` frame flag), reassembles bytes into DAT_WIDTH-bit samples, and presents each sample tagged with stream index and sample address on a one-word valid/ready output. Sits in the system clock domain between the grabber's report port and a host/debug sink, and flags short, long or truncated reports.

## Interface
- DAT_WIDTH, 72: sample width in bits; multiple of 8; BYTES = DAT_WIDTH/8.
- ADDR_BITS, 4: log2 of samples per stream; DEPTH = 2^ADDR_BITS.
- clk_sys  input  1  system clock; all logic on its rising edge.
- rst_sys_n  input  1  reset; synchronous and active-low.
- din  input  8  report byte.
- din_valid  input  1  din holds a byte.
- din_ready  output  1  byte accepted when din_valid & din_ready & reporting.
- reporting  input  1  high for the duration of one report frame.
- word_out  output  DAT_WIDTH  reassembled sample.
- word_stream  output  2  stream index 0..3 of word_out.
- word_addr  output  ADDR_BITS  sample index within stream, 0 = oldest.
- word_valid  output  1  word_out/tags valid; held until word_ready.
- word_ready  input  1  sink accepts word when word_valid & word_ready.
- frame_done  output  1  one-cycle pulse: frame ended with exactly 4*DEPTH*BYTES bytes.
- frame_err  output  1  one-cycle pulse: frame ended short, long, or mid-word.

## Operation
- Frame format: stream 0..3 in order; per stream DEPTH samples, oldest first; per sample BYTES bytes, most significant byte first.
- States: IDLE, RECV.
- IDLE: din_ready = 1; bytes with reporting low are dropped silently. reporting sampled high -> RECV; byte counter, sample counter, stream counter, overflow flag cleared. A byte accepted in the same cycle reporting is first seen high is the first frame byte.
- RECV: each accepted byte shifts into a BYTES-deep assembly register; on the BYTES-th byte the assembled word, stream and address load the output register and word_valid sets.
- din_ready = !word_valid | word_ready (combinational through word_ready); no byte is ever lost.
- Counters: byte-in-word 0..BYTES-1, address 0..DEPTH-1 wrapping into stream 0..3. After stream 3 / address DEPTH-1 completes, further bytes are accepted and discarded, overflow flag set, no words emitted.
- RECV, reporting sampled low -> IDLE; same cycle evaluates: total count exact and no overflow -> frame_done; otherwise frame_err. Partial assembly discarded. A word already in the output register is still delivered.
- Output register is independent of state: word_valid clears only on handshake or reset.

## Timing
- Reset (rst_sys_n low at a clock edge): state IDLE; din_ready 0 while in reset, 1 the cycle after release; word_out 0, word_stream 0, word_addr 0, word_valid 0, frame_done 0, frame_err 0; all counters 0. Reset mid-frame abandons the frame with no pulse.
- Latency: last byte of a sample accepted at edge N -> word_valid high after edge N; sink may take it in cycle N+1.
- Back-to-back: with word_ready tied high, sustained 1 byte/clock, one word per BYTES clocks.
- Simultaneous word handshake and final byte of next word: output register reloads same edge, word_valid stays high.
- frame_done/frame_err: asserted the cycle after the edge at which reporting is sampled low in RECV; never both.

## Configuration
- REPORT_UNPACK_LSB_FIRST_EN: defined -> bytes within a sample are least significant first (first byte lands in word_out[7:0]). Undefined (default) -> most significant first (first byte lands in word_out[DAT_WIDTH-1:DAT_WIDTH-8]). Counters, tags and error rules unchanged.

## Test plan
- DAT_WIDTH 72, ADDR_BITS 4, word_ready high, 576 bytes at 1/clk, byte k = k[7:0] -> 64 words, stream 0 addr 0 first word 0x000102030405060708, last word stream 3 addr 15, frame_done one pulse, frame_err never.
- Same frame, word_ready toggling 1-of-3 cycles, din_valid random -> identical 64 words in order, no byte dropped, din_ready low only while word_valid & !word_ready.
- reporting drops after 300 bytes -> 33 words emitted (3 trailing bytes discarded), frame_err pulse, next full frame decodes cleanly.
- 580 bytes in one frame -> 64 words, 4 extra bytes absorbed, frame_err pulse, no frame_done.
- Bytes with reporting low in IDLE -> din_ready 1, no words, no pulses; rst_sys_n low mid-frame after 100 bytes -> all outputs 0, no pulse, following frame clean.
- REPORT_UNPACK_LSB_FIRST_EN defined, first scenario -> first word 0x080706050403020100.
